// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// MULT/MULTU via shift-add, DIV/DIVU via restoring division, one bit per cycle.
module mul_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned W2 = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIXUP = 2'd2} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               sign_a;
  logic               sign_b;
  logic               b_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   d;
  logic [W2-1:0]      acc;

  logic               sgn_op;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_up;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [W2-1:0]      acc_step;
  logic [W2-1:0]      prod_fix;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Operand magnitudes; only signed ops take the absolute value.
  always_comb begin
    sgn_op = op[0];
    abs_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    abs_b  = (sgn_op && b[WIDTH-1]) ? -b : b;
  end

  // One iteration step plus the sign-corrected final results.
  always_comb begin
    mul_sum  = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? d : {WIDTH{1'b0}})};
    div_up   = acc[W2-1:WIDTH-1];
    div_diff = div_up - {1'b0, d};
    div_ge   = (div_up >= {1'b0, d});
    if (is_div) begin
      acc_step = {(div_ge ? WIDTH'(div_diff) : WIDTH'(div_up)), acc[WIDTH-2:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
    quo      = acc[WIDTH-1:0];
    rem      = acc[W2-1:WIDTH];
    prod_fix = (sign_a ^ sign_b) ? -acc : acc;
    quo_fix  = (sign_a ^ sign_b) ? -quo : quo;
    rem_fix  = sign_a ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      b_zero      <= 1'b0;
      a_raw       <= '0;
      d           <= '0;
      acc         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            is_div <= op[1];
            sign_a <= sgn_op & a[WIDTH-1];
            sign_b <= sgn_op & b[WIDTH-1];
            b_zero <= (b == '0);
            a_raw  <= a;
            d      <= op[1] ? abs_b : abs_a;
            acc    <= {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
            cnt    <= CNT_W'(WIDTH - 1);
            busy   <= 1'b1;
            state  <= CALC;
          end else begin
            // MTHI/MTLO only land while idle with no launch pending.
            if (wr_hi) hi <= wr_data;
            if (wr_lo) lo <= wr_data;
          end
        end
        CALC: begin
          acc <= acc_step;
          if (cnt == '0) state <= FIXUP;
          else           cnt   <= cnt - CNT_W'(1);
        end
        FIXUP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
          if (!is_div) begin
            hi <= prod_fix[W2-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end else if (b_zero) begin
            hi          <= a_raw;
            lo          <= '1;
            div_by_zero <= 1'b1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised iterative multiply/divide unit for the multi-cycle MIPS core. It owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over WIDTH+1 cycles using a start/busy/done handshake.
- Sits beside the ALU in the execute stage. The core's control FSM stalls on busy and reads hi/lo for MFHI/MFLO.
- Also supports MTHI/MTLO writes while idle.

Parameters:
- WIDTH, 32: operand width and HI/LO width. Must be at least 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request new operation; sampled only when busy=0
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  rs operand (multiplicand or dividend); captured with start
- b  in  WIDTH  rt operand (multiplier or divisor); captured with start
- wr_hi  in  1  MTHI strobe
- wr_lo  in  1  MTLO strobe
- wr_data  in  WIDTH  MTHI/MTLO data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- div_by_zero  out  1  asserted together with done when a divide had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; busy=0, done=0, div_by_zero=0, hi=0, lo=0; counter and internal operand registers cleared.
- Reset mid-operation aborts immediately. No done pulse is issued, and hi/lo clear to 0.
- States are IDLE, CALC and FIXUP.
- IDLE to CALC: when start=1 at edge E0 and busy=0.
  - Latch op and |a|, |b|. The magnitude is taken only for signed ops; the original signs are also latched.
  - Set busy=1 and counter=WIDTH-1.
- CALC: one iteration per edge; the counter decrements. After WIDTH iterations (edges E0+1 .. E0+WIDTH) go to FIXUP.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring division, one quotient bit per cycle.
- FIXUP, one cycle, applies sign correction at edge E0+WIDTH+1 and returns to IDLE.
  - MULT: negate the 2*WIDTH product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - At the same edge: hi/lo load the result, done=1, busy=0.
- Latency: done is high during the cycle after edge E0+WIDTH+1. busy is high for exactly WIDTH+1 cycles.
- done and div_by_zero are single-cycle pulses and clear at the next edge.
- Results:
  - Multiply: {hi,lo} = product.
  - Divide: lo = quotient truncated toward zero; hi = remainder.
  - Signed overflow, most-negative / -1: lo = most-negative (wraps), hi = 0. No flag is raised.
  - Divide by zero: normal latency; hi = a (original value), lo = all ones, div_by_zero=1 with done.
- Handshake:
  - start while busy=1 is ignored: no queueing, operands are not re-captured.
  - start in the same cycle as done=1 is accepted, since the state is already IDLE.
  - The operation launches at that edge, so back-to-back throughput is WIDTH+1 cycles.
- MTHI/MTLO:
  - When IDLE and start=0, wr_hi/wr_lo load wr_data into hi/lo at the next edge.
  - wr_hi and wr_lo together load both registers.
  - Writes while busy=1 are dropped.
  - If start=1 and wr_* are asserted in the same cycle, start wins and the write is dropped.
- hi/lo hold their value between completions and writes. Reading while busy returns the previous result.
- op, a and b may change after E0 without effect.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF, start at E0 -> busy for 33 cycles; done pulse after E0+33; hi=0xFFFFFFFE, lo=0x00000001, div_by_zero=0.
- MULT a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Then DIV a=0xFFFFFFF9 (-7) b=2 started in the done cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; the second done comes exactly 33 cycles after the first.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=100 b=7 -> lo=14, hi=2.
- DIVU a=0x12345678 b=0 -> done with div_by_zero=1; hi=0x12345678, lo=0xFFFFFFFF; both flags clear the next cycle.
- Busy interference: start plus new operands at E0+5 -> ignored, result unchanged. wr_hi=1 wr_data=0xAAAA while busy -> dropped. wr_lo=1 wr_data=0x55 when idle -> lo=0x55 next edge, hi unchanged. start plus wr_hi in the same cycle -> hi not written.
- rst=1 at E0+10 of a MULTU -> next edge busy=0, hi=lo=0, no done pulse. A fresh MULTU 6*7 afterwards gives lo=42, hi=0 with nominal latency. WIDTH=8 build: MULT 0x80*0x80 -> hi=0x40, lo=0x00 after 9 cycles.
